// File: rtl/ps2_keystream_decoder.sv
// PS/2 set-2 scan-code stream decoder.
// Tracks the E0/F0 prefix state, the shift keys and typematic repeats, and
// translates key presses into ASCII characters. The characters are buffered in a
// first-word-fall-through FIFO.
// Output handshake: ascii_out is the head entry whenever ascii_valid=1 and stays
// steady until the consumer accepts it. A pop happens on the edge where
// ascii_valid & ascii_ready are both high. ascii_ready while empty is ignored.
module ps2_keystream_decoder #(
  parameter int FIFO_DEPTH   = 8,
  parameter int LOWERCASE_EN = 1,
  parameter int REPEAT_EN    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    code_in,
  input  logic                          code_valid,
  output logic [7:0]                    ascii_out,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          shift_active,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic        is_make, is_break, is_ext;
  logic [8:0]  key;
  logic [8:0]  last_make;
  logic        shift_l, shift_r;
  logic        is_shift_key, repeat_hit, make_ok;
  logic        is_letter;
  logic [7:0]  letter_up;
  logic        char_ok;
  logic [7:0]  char;
  logic        push, pop, do_push, full, empty;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Prefix state register; advances only on a byte strobe.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (code_valid) state <= state_nxt;
  end

  // Prefix next-state and classification of the current byte.
  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_break  = 1'b0;
    is_ext    = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (code_in == 8'hE0)      state_nxt = EXT;
          else if (code_in == 8'hF0) state_nxt = BRK;
          else begin
            is_make   = 1'b1;
            state_nxt = IDLE;
          end
        end
        EXT: begin
          if (code_in == 8'hF0)      state_nxt = EXT_BRK;
          else if (code_in == 8'hE0) state_nxt = EXT;
          else begin
            is_make   = 1'b1;
            is_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          is_break  = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          is_break  = 1'b1;
          is_ext    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign key          = {is_ext, code_in};
  assign is_shift_key = !is_ext && (code_in == 8'h12 || code_in == 8'h59);
  assign repeat_hit   = (REPEAT_EN == 0) && (key == last_make);
  // Shift keys are modifiers: they never enter the repeat filter.
  assign make_ok      = is_make && !is_shift_key && !repeat_hit;
  assign shift_active = shift_l | shift_r;

  // Shift flags and last held key; updated even when the FIFO drops the char.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      last_make <= 9'h000;
    end else begin
      if (is_make && is_shift_key) begin
        if (code_in == 8'h12) shift_l <= 1'b1;
        else                  shift_r <= 1'b1;
      end
      if (make_ok) last_make <= key;
      if (is_break) begin
        if (is_shift_key && code_in == 8'h12) shift_l <= 1'b0;
        if (is_shift_key && code_in == 8'h59) shift_r <= 1'b0;
        if (key == last_make) last_make <= 9'h000;
      end
    end
  end

  // Letter lookup, uppercase form.
  always_comb begin
    is_letter = 1'b1;
    letter_up = 8'h00;
    case (code_in)
      8'h1C: letter_up = 8'h41;  8'h32: letter_up = 8'h42;
      8'h21: letter_up = 8'h43;  8'h23: letter_up = 8'h44;
      8'h24: letter_up = 8'h45;  8'h2B: letter_up = 8'h46;
      8'h34: letter_up = 8'h47;  8'h33: letter_up = 8'h48;
      8'h43: letter_up = 8'h49;  8'h3B: letter_up = 8'h4A;
      8'h42: letter_up = 8'h4B;  8'h4B: letter_up = 8'h4C;
      8'h3A: letter_up = 8'h4D;  8'h31: letter_up = 8'h4E;
      8'h44: letter_up = 8'h4F;  8'h4D: letter_up = 8'h50;
      8'h15: letter_up = 8'h51;  8'h2D: letter_up = 8'h52;
      8'h1B: letter_up = 8'h53;  8'h2C: letter_up = 8'h54;
      8'h3C: letter_up = 8'h55;  8'h2A: letter_up = 8'h56;
      8'h1D: letter_up = 8'h57;  8'h22: letter_up = 8'h58;
      8'h35: letter_up = 8'h59;  8'h1A: letter_up = 8'h5A;
      default: is_letter = 1'b0;
    endcase
  end

  // Scan code to ASCII; char_ok=0 means the make produces nothing.
  always_comb begin
    char_ok = 1'b1;
    char    = 8'h00;
    if (is_ext) begin
      case (code_in)
        8'h4A:   char = 8'h2F;
        8'h5A:   char = 8'h0A;
        default: char_ok = 1'b0;
      endcase
    end else if (is_letter) begin
      char = (LOWERCASE_EN != 0 && !shift_active) ? (letter_up | 8'h20) : letter_up;
    end else begin
      case (code_in)
        8'h16: char = shift_active ? 8'h21 : 8'h31;
        8'h1E: char = shift_active ? 8'h40 : 8'h32;
        8'h26: char = shift_active ? 8'h23 : 8'h33;
        8'h25: char = shift_active ? 8'h24 : 8'h34;
        8'h2E: char = shift_active ? 8'h25 : 8'h35;
        8'h36: char = shift_active ? 8'h5E : 8'h36;
        8'h3D: char = shift_active ? 8'h26 : 8'h37;
        8'h3E: char = shift_active ? 8'h2A : 8'h38;
        8'h46: char = shift_active ? 8'h28 : 8'h39;
        8'h45: char = shift_active ? 8'h29 : 8'h30;
        8'h4E: char = shift_active ? 8'h5F : 8'h2D;
        8'h55: char = shift_active ? 8'h2B : 8'h3D;
        8'h70: char = 8'h30;  8'h69: char = 8'h31;
        8'h72: char = 8'h32;  8'h7A: char = 8'h33;
        8'h6B: char = 8'h34;  8'h73: char = 8'h35;
        8'h74: char = 8'h36;  8'h6C: char = 8'h37;
        8'h75: char = 8'h38;  8'h7D: char = 8'h39;
        8'h29: char = 8'h20;  8'h5A: char = 8'h0A;
        8'h66: char = 8'h08;
        8'h7B: char = 8'h2D;  8'h7C: char = 8'h2A;
        8'h79: char = 8'h2B;
        default: char_ok = 1'b0;
      endcase
    end
  end

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = make_ok && char_ok;
  assign pop     = ascii_ready && !empty;
  assign do_push = push && (!full || pop);

  // FIFO storage; contents need no reset, the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= char;
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !pop)      count <= count + CNT_ONE;
      else if (pop && !do_push) count <= count - CNT_ONE;
      overflow <= push && full && !pop;
    end
  end

  assign ascii_valid = !empty;
  assign ascii_out   = empty ? 8'h00 : mem[rd_ptr];
  assign fill_level  = count;

endmodule

// File: tb/tb_ps2_keystream_decoder.sv
// Directed bench for ps2_keystream_decoder: three instances cover the default
// build, typematic repeat enabled, and a 4-entry FIFO.
module tb_ps2_keystream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_in = 8'h00;
  logic       cv_a = 1'b0, cv_r = 1'b0, cv_f = 1'b0;
  logic       rdy_a = 1'b0, rdy_r = 1'b0, rdy_f = 1'b0;

  logic [7:0] out_a, out_r, out_f;
  logic       val_a, val_r, val_f;
  logic [3:0] fill_a, fill_r;
  logic [2:0] fill_f;
  logic       sh_a, sh_r, sh_f;
  logic       ovf_a, ovf_r, ovf_f;

  int total = 0;
  int bad   = 0;

  ps2_keystream_decoder dut_a (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv_a),
    .ascii_out(out_a), .ascii_valid(val_a), .ascii_ready(rdy_a),
    .fill_level(fill_a), .shift_active(sh_a), .overflow(ovf_a)
  );

  ps2_keystream_decoder #(.REPEAT_EN(1)) dut_r (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv_r),
    .ascii_out(out_r), .ascii_valid(val_r), .ascii_ready(rdy_r),
    .fill_level(fill_r), .shift_active(sh_r), .overflow(ovf_r)
  );

  ps2_keystream_decoder #(.FIFO_DEPTH(4)) dut_f (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(cv_f),
    .ascii_out(out_f), .ascii_valid(val_f), .ascii_ready(rdy_f),
    .fill_level(fill_f), .shift_active(sh_f), .overflow(ovf_f)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] get_out(input int sel);
    if (sel == 0) return {24'h0, out_a};
    else if (sel == 1) return {24'h0, out_r};
    else return {24'h0, out_f};
  endfunction

  function automatic logic [31:0] get_val(input int sel);
    if (sel == 0) return {31'h0, val_a};
    else if (sel == 1) return {31'h0, val_r};
    else return {31'h0, val_f};
  endfunction

  function automatic logic [31:0] get_fill(input int sel);
    if (sel == 0) return {28'h0, fill_a};
    else if (sel == 1) return {28'h0, fill_r};
    else return {29'h0, fill_f};
  endfunction

  function automatic logic [31:0] get_ovf(input int sel);
    if (sel == 0) return {31'h0, ovf_a};
    else if (sel == 1) return {31'h0, ovf_r};
    else return {31'h0, ovf_f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rdy(input int sel, input logic v);
    if (sel == 0) rdy_a = v;
    else if (sel == 1) rdy_r = v;
    else rdy_f = v;
  endtask

  // Present one byte for exactly one rising edge; called at a negedge.
  task automatic send(input int sel, input logic [7:0] b);
    code_in = b;
    if (sel == 0) cv_a = 1'b1;
    else if (sel == 1) cv_r = 1'b1;
    else cv_f = 1'b1;
    @(negedge clk);
    cv_a = 1'b0;
    cv_r = 1'b0;
    cv_f = 1'b0;
  endtask

  // Check the head character, then accept it for one edge.
  task automatic take(input int sel, input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, get_val(sel), 32'd1);
    chk({tag, "_char"}, get_out(sel), {24'h0, exp});
    set_rdy(sel, 1'b1);
    @(negedge clk);
    set_rdy(sel, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out", get_out(0), 32'h00);
    chk("rst_valid", get_val(0), 32'd0);
    chk("rst_fill", get_fill(0), 32'd0);
    chk("rst_shift", {31'h0, sh_a}, 32'd0);
    chk("rst_ovf", get_ovf(0), 32'd0);
    chk("rst_fill_f", get_fill(2), 32'd0);

    // Plain make/break of A
    send(0, 8'h1C);
    chk("a_valid_rise", get_val(0), 32'd1);
    chk("a_char", get_out(0), 32'h61);
    chk("a_fill", get_fill(0), 32'd1);
    send(0, 8'hF0);
    send(0, 8'h1C);
    chk("a_brk_fill", get_fill(0), 32'd1);
    take(0, "a_pop", 8'h61);
    chk("a_empty", get_val(0), 32'd0);

    // Shifted digit, then unshifted
    send(0, 8'h12);
    chk("sh_on", {31'h0, sh_a}, 32'd1);
    chk("sh_make_quiet", get_fill(0), 32'd0);
    send(0, 8'h16);
    send(0, 8'hF0);
    send(0, 8'h16);
    chk("sh_still", {31'h0, sh_a}, 32'd1);
    send(0, 8'hF0);
    send(0, 8'h12);
    chk("sh_off", {31'h0, sh_a}, 32'd0);
    send(0, 8'h16);
    chk("sh_fill", get_fill(0), 32'd2);
    take(0, "sh_bang", 8'h21);
    take(0, "sh_one", 8'h31);

    // Extended keys
    send(0, 8'hE0); send(0, 8'h4A);
    send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h4A);
    send(0, 8'hE0); send(0, 8'h75);
    chk("ext_fill", get_fill(0), 32'd1);
    take(0, "ext_slash", 8'h2F);
    // ready while empty is ignored
    rdy_a = 1'b1;
    @(negedge clk);
    chk("empty_ready", get_fill(0), 32'd0);
    // push and pop together on an empty FIFO: only the push happens;
    // also shows the prefix FSM is back in IDLE (29 is a plain make)
    send(0, 8'h29);
    rdy_a = 1'b0;
    chk("empty_pushpop", get_fill(0), 32'd1);
    take(0, "space", 8'h20);

    // Typematic repeat filter
    send(0, 8'h23); send(0, 8'h23); send(0, 8'h23);
    send(0, 8'hF0); send(0, 8'h23); send(0, 8'h23);
    chk("rep0_fill", get_fill(0), 32'd2);
    take(0, "rep0_d0", 8'h64);
    take(0, "rep0_d1", 8'h64);
    chk("rep0_empty", get_val(0), 32'd0);
    send(1, 8'h23); send(1, 8'h23); send(1, 8'h23);
    send(1, 8'hF0); send(1, 8'h23); send(1, 8'h23);
    chk("rep1_fill", get_fill(1), 32'd4);
    for (int i = 0; i < 4; i++) take(1, "rep1_d", 8'h64);
    chk("rep1_empty", get_val(1), 32'd0);

    // Overflow on the 4-deep FIFO: letters a..i
    begin
      logic [7:0] codes [9];
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      for (int i = 0; i < 9; i++) begin
        send(2, codes[i]);
        chk("ovf_pulse", get_ovf(2), (i >= 4) ? 32'd1 : 32'd0);
        chk("ovf_fill", get_fill(2), (i >= 4) ? 32'd4 : 32'(i + 1));
        send(2, 8'hF0);
        chk("ovf_clear", get_ovf(2), 32'd0);
        send(2, codes[i]);
      end
    end
    take(2, "drain_a", 8'h61);
    take(2, "drain_b", 8'h62);
    take(2, "drain_c", 8'h63);
    take(2, "drain_d", 8'h64);
    chk("drain_empty", get_fill(2), 32'd0);

    // Offset the pointers, then fill across the wrap point
    send(2, 8'h24);
    take(2, "off_e", 8'h65);
    send(2, 8'h1C); send(2, 8'h32); send(2, 8'h21); send(2, 8'h23);
    chk("wrap_full", get_fill(2), 32'd4);
    // full: push and pop on the same edge
    rdy_f = 1'b1;
    send(2, 8'h2B);
    rdy_f = 1'b0;
    chk("full_pushpop_fill", get_fill(2), 32'd4);
    chk("full_pushpop_ovf", get_ovf(2), 32'd0);
    take(2, "wrap_b", 8'h62);
    take(2, "wrap_c", 8'h63);
    take(2, "wrap_d", 8'h64);
    take(2, "wrap_f", 8'h66);
    chk("wrap_empty", get_val(2), 32'd0);

    // Reset with a pending break prefix
    send(0, 8'h1C);
    chk("mid_fill", get_fill(0), 32'd1);
    send(0, 8'hF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_flush", get_fill(0), 32'd0);
    chk("mid_valid", get_val(0), 32'd0);
    send(0, 8'h1C);
    chk("mid_refill", get_fill(0), 32'd1);
    take(0, "mid_a", 8'h61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keystream_decoder.md
Name: ps2_keystream_decoder

Overview:
Sits between the PS/2 byte receiver and the character consumers (display / calculator input logic). It consumes raw scan-code bytes and tracks the PS/2 set-2 protocol state: make, break (F0), extended (E0), shift and typematic repeat. It translates key presses into ASCII characters and buffers them in a parametrised first-word-fall-through FIFO with a valid/ready output handshake.

Parameters:
FIFO_DEPTH, 8, character buffer entries; power of 2, minimum 2
LOWERCASE_EN, 1, 1: letters are lowercase unshifted and uppercase with shift; 0: letters are always uppercase
REPEAT_EN, 0, 1: typematic repeats are emitted; 0: a repeated make of the held key is dropped

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
code_in  in  8  scan-code byte from the PS/2 receiver
code_valid  in  1  one-cycle strobe; code_in is valid this cycle
ascii_out  out  8  FIFO head character
ascii_valid  out  1  FIFO not empty
ascii_ready  in  1  consumer accepts ascii_out this cycle
fill_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
shift_active  out  1  left or right shift is held
overflow  out  1  one-cycle pulse when a character is dropped because the FIFO is full

Behaviour:
- Reset (synchronous, active-high): prefix FSM goes to IDLE, shift flags clear, last_make clears to 00, FIFO flushes. Outputs: ascii_out=00, ascii_valid=0, fill_level=0, shift_active=0, overflow=0. A reset mid-sequence (for example after F0) discards the pending prefix.
- Prefix FSM states: IDLE, BRK, EXT, EXT_BRK. The FSM advances only on code_valid.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; any other byte is an extended make -> IDLE.
  - BRK / EXT_BRK: the byte is a break (normal / extended) -> IDLE.
- Make handling:
  - 12 or 59 sets the left or right shift flag; nothing is emitted.
  - If REPEAT_EN=0 and the code equals last_make (for extended codes, the compare includes the E0 flag), the make is dropped. Otherwise last_make is updated.
- Break handling:
  - 12 or 59 clears the corresponding shift flag.
  - A break matching last_make clears last_make.
  - Nothing is emitted.
- Unshifted translation:
  - Digits 0-9: top row 45,16,1E,26,25,2E,36,3D,3E,46 and keypad 70,69,72,7A,6B,73,74,6C,75,7D -> 30-39.
  - Letters: standard set-2 codes (1C=A ... 1A=Z). LOWERCASE_EN=1 and shift clear -> 61-7A; otherwise 41-5A.
  - 29 -> 20, 5A -> 0A, 66 -> 08, 4E -> 2D, 55 -> 3D.
  - Keypad: 7B -> 2D, 7C -> 2A, 79 -> 2B.
  - Extended: E0 4A -> 2F, E0 5A -> 0A.
  - All other makes, including any other extended code, are dropped silently.
- Shifted translation (shift_active=1):
  - Top-row digits 1..9,0 -> 21,40,23,24,25,5E,26,2A,28,29.
  - 4E -> 5F, 55 -> 2B.
  - Keypad and extended keys are unaffected by shift.
- Latency: a translatable make strobed on code_valid at edge k is written at edge k. After that edge, ascii_valid=1 and ascii_out shows the head entry (one cycle latency when the FIFO was empty). There is no same-cycle bypass.
- Handshake:
  - A pop occurs on ascii_valid & ascii_ready.
  - ascii_ready while empty has no effect.
  - ascii_out holds steady while ascii_valid=1 and ascii_ready=0.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - fill_level updates each edge: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - Full with push and no pop: the character is dropped and overflow pulses for one cycle. Translation state (shift, last_make) still updates.
  - Full with push and pop in the same cycle: both occur, no overflow.
  - Empty with push and pop in the same cycle: the pop is ignored and the push occurs.
- Back-to-back code_valid on consecutive cycles must be accepted.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> single entry 61 ('a'); ascii_valid rises the cycle after 1C; fill_level=1; the break emits nothing.
- 12, 16, F0 16, F0 12, 16 -> outputs 21 then 31; shift_active is 1 between 12 and F0 12; the 12 make and both breaks emit nothing.
- E0 4A, E0 F0 4A, E0 75 -> output 2F only; the FSM returns to IDLE after each sequence; E0 75 is dropped.
- REPEAT_EN=0: 23, 23, 23, F0 23, 23 -> exactly two 44/64 entries. REPEAT_EN=1: the same sequence -> four entries.
- FIFO_DEPTH=4, ascii_ready=0, nine letter makes interleaved with breaks (five overflow) -> fill_level saturates at 4, overflow pulses on makes 5-9. Then ready=1 -> exactly the first four characters drain in order, with wrap-around verified.
- FIFO full, a push and a pop in the same cycle -> fill_level stays 4, no overflow. Assert rst after 1C F0 (pending break), then send 1C -> 61 is emitted (prefix discarded, FIFO flushed to fill_level=0 first).
